// File: rtl/sampler_dma_pkg.sv
// -----------------------------------------------------------------------------
// sampler_dma_pkg
// Shared types, constants and the round-robin pick helper for the sampler DMA
// read arbiter.
//   arb_state_t : AR channel FSM states (IDLE, ADDR)
//   DMA_ARLEN_W : AXI ARLEN width
//   DMA_STATS_W : width of each per-voice grant counter (optional statistics)
//   rr_pick     : first requesting index at or after ptr, wrapping modulo n
// -----------------------------------------------------------------------------
package sampler_dma_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ADDR = 1'b1
  } arb_state_t;

  localparam int DMA_ARLEN_W = 8;
  localparam int DMA_STATS_W = 16;
  localparam int RR_MAX_N    = 16;

  // Scans n candidates starting at ptr. The caller zero-extends req to
  // RR_MAX_N bits and only uses the result when req is non-empty.
  function automatic logic [3:0] rr_pick(input logic [RR_MAX_N-1:0] req,
                                         input logic [3:0]          ptr,
                                         input int                  n);
    logic [3:0] pick;
    logic       found;
    int         idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < RR_MAX_N; k++) begin
      idx = (int'(ptr) + k) % n;
      if (!found && (k < n) && req[idx]) begin
        pick  = 4'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sampler_dma_rr_arbiter.sv
// -----------------------------------------------------------------------------
// sampler_dma_rr_arbiter
// Combinational round-robin pick plus the rotating priority pointer.
//   clk, rst_n   : clock, synchronous active-low reset (pointer -> 0)
//   req          : eligible voices
//   advance      : a grant was accepted this cycle; move pointer past it
//   advance_idx  : index of the accepted grant
//   grant_valid  : at least one voice is eligible
//   grant_idx    : first eligible voice at or after the pointer
// -----------------------------------------------------------------------------
module sampler_dma_rr_arbiter
  import sampler_dma_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  input  logic [IDX_W-1:0] advance_idx,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [RR_MAX_N-1:0] req_ext;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
  end

  assign grant_valid = |req;
  assign grant_idx   = IDX_W'(rr_pick(req_ext, 4'(ptr_q), N));

  // Pointer lands just past the voice that was served, so it drops to
  // lowest priority for the next decision.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (int'(advance_idx) == N - 1) ? '0 : advance_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sampler_dma_read_arbiter.sv
// -----------------------------------------------------------------------------
// sampler_dma_read_arbiter
// Shares one AXI4 read channel between NUM_VOICES voice DMA FSMs. AR requests
// are arbitrated round-robin (ARID = voice index); R beats are routed back by
// RID. One outstanding burst per voice; beats for idle/unknown IDs are dropped
// and flagged on the sticky rid_error.
// Ports:
//   axi_dma_master_aclk/aresetn : clock, synchronous active-low reset
//   voice_req_valid/addr/len    : per-voice burst request (held until ready)
//   voice_req_ready             : one-cycle accept pulse (AR handshake)
//   voice_rdata/rvalid/rlast    : registered R beat, rvalid one-hot per voice
//   voice_busy                  : burst outstanding per voice
//   axi_dma_master_ar*          : AXI AR channel
//   axi_dma_master_r*           : AXI R channel (rready tied high)
//   rid_error                   : sticky unexpected-beat flag
// Optional: define SAMPLER_DMA_ARB_STATS_EN to add grant_count, a saturating
// 16-bit count of accepted AR handshakes per voice.
// -----------------------------------------------------------------------------
module sampler_dma_read_arbiter
  import sampler_dma_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int ID_W       = 4
) (
  input  logic                              axi_dma_master_aclk,
  input  logic                              axi_dma_master_aresetn,
  input  logic [NUM_VOICES-1:0]             voice_req_valid,
  output logic [NUM_VOICES-1:0]             voice_req_ready,
  input  logic [NUM_VOICES*ADDR_W-1:0]      voice_req_addr,
  input  logic [NUM_VOICES*DMA_ARLEN_W-1:0] voice_req_len,
  output logic [DATA_W-1:0]                 voice_rdata,
  output logic [NUM_VOICES-1:0]             voice_rvalid,
  output logic                              voice_rlast,
  output logic [NUM_VOICES-1:0]             voice_busy,
  output logic [ADDR_W-1:0]                 axi_dma_master_araddr,
  output logic [DMA_ARLEN_W-1:0]            axi_dma_master_arlen,
  output logic [ID_W-1:0]                   axi_dma_master_arid,
  output logic                              axi_dma_master_arvalid,
  input  logic                              axi_dma_master_arready,
  input  logic [DATA_W-1:0]                 axi_dma_master_rdata,
  input  logic [ID_W-1:0]                   axi_dma_master_rid,
  input  logic                              axi_dma_master_rvalid,
  input  logic                              axi_dma_master_rlast,
  output logic                              axi_dma_master_rready,
  output logic                              rid_error
`ifdef SAMPLER_DMA_ARB_STATS_EN
  ,
  output logic [NUM_VOICES*DMA_STATS_W-1:0] grant_count
`endif
);

  localparam int IDX_W = $clog2(NUM_VOICES);

  arb_state_t               state_q, state_d;
  logic                     arvalid_q, arvalid_d;
  logic [ADDR_W-1:0]        araddr_q, araddr_d;
  logic [DMA_ARLEN_W-1:0]   arlen_q, arlen_d;
  logic [IDX_W-1:0]         grant_q, grant_d;
  logic [NUM_VOICES-1:0]    busy_q, busy_d;
  logic [NUM_VOICES-1:0]    rvalid_q;
  logic                     rlast_q;
  logic [DATA_W-1:0]        rdata_q;
  logic                     rid_error_q;

  logic [NUM_VOICES-1:0]    eligible;
  logic                     pick_valid;
  logic [IDX_W-1:0]         pick_idx;
  logic                     ar_hs;
  logic [NUM_VOICES-1:0]    grant_onehot;
  logic [NUM_VOICES-1:0]    rid_onehot;
  logic                     beat_ok;

  assign eligible = voice_req_valid & ~busy_q;
  assign ar_hs    = arvalid_q & axi_dma_master_arready;

  sampler_dma_rr_arbiter #(
    .N     (NUM_VOICES),
    .IDX_W (IDX_W)
  ) u_rr (
    .clk         (axi_dma_master_aclk),
    .rst_n       (axi_dma_master_aresetn),
    .req         (eligible),
    .advance     (ar_hs),
    .advance_idx (grant_q),
    .grant_valid (pick_valid),
    .grant_idx   (pick_idx)
  );

  // An out-of-range RID matches no one-hot bit, so it can never hit busy_q.
  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_decode
    assign grant_onehot[gi] = (grant_q == IDX_W'(gi));
    assign rid_onehot[gi]   = (axi_dma_master_rid == ID_W'(gi));
  end

  assign beat_ok = axi_dma_master_rvalid & |(rid_onehot & busy_q);

  // AR FSM: IDLE picks and loads the payload; ADDR holds it until arready.
  always_comb begin
    state_d   = state_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    grant_d   = grant_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d   = ADDR;
          arvalid_d = 1'b1;
          grant_d   = pick_idx;
          araddr_d  = voice_req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          arlen_d   = voice_req_len[int'(pick_idx)*DMA_ARLEN_W +: DMA_ARLEN_W];
        end
      end
      ADDR: begin
        if (axi_dma_master_arready) begin
          state_d   = IDLE;
          arvalid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Set and clear always target different voices: a busy voice is never
  // granted, so its burst cannot be both launched and completed together.
  always_comb begin
    busy_d = busy_q;
    if (ar_hs)                         busy_d = busy_d | grant_onehot;
    if (beat_ok && axi_dma_master_rlast) busy_d = busy_d & ~rid_onehot;
  end

  always_ff @(posedge axi_dma_master_aclk) begin
    if (!axi_dma_master_aresetn) begin
      state_q     <= IDLE;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      grant_q     <= '0;
      busy_q      <= '0;
      rvalid_q    <= '0;
      rlast_q     <= 1'b0;
      rdata_q     <= '0;
      rid_error_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      rvalid_q  <= beat_ok ? rid_onehot : '0;
      rlast_q   <= beat_ok & axi_dma_master_rlast;
      if (axi_dma_master_rvalid) rdata_q <= axi_dma_master_rdata;
      if (axi_dma_master_rvalid && !beat_ok) rid_error_q <= 1'b1;
    end
  end

  assign voice_req_ready        = ar_hs ? grant_onehot : '0;
  assign voice_busy             = busy_q;
  assign voice_rvalid           = rvalid_q;
  assign voice_rlast            = rlast_q;
  assign voice_rdata            = rdata_q;
  assign rid_error              = rid_error_q;
  assign axi_dma_master_arvalid = arvalid_q;
  assign axi_dma_master_araddr  = araddr_q;
  assign axi_dma_master_arlen   = arlen_q;
  assign axi_dma_master_arid    = ID_W'(grant_q);
  assign axi_dma_master_rready  = 1'b1;

`ifdef SAMPLER_DMA_ARB_STATS_EN
  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_stats
    logic [DMA_STATS_W-1:0] cnt_q;
    always_ff @(posedge axi_dma_master_aclk) begin
      if (!axi_dma_master_aresetn) begin
        cnt_q <= '0;
      end else if (ar_hs && grant_onehot[gi] && (cnt_q != {DMA_STATS_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
    assign grant_count[gi*DMA_STATS_W +: DMA_STATS_W] = cnt_q;
  end
`endif

endmodule
